// File: rtl/tlb_miss_sequencer.sv
// Sequences ITLB/DTLB misses through the shared STLB and page walker.
// One miss in flight at a time; STLB flushes are serialised between misses.
module tlb_miss_sequencer #(
    parameter int VA_W         = 64,
    parameter int PA_W         = 64,
    parameter int PCID_W       = 12,
    parameter int STLB_LAT     = 1,
    parameter int WALK_TIMEOUT = 255
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [1:0]          req_valid,
    input  logic [2*VA_W-1:0]   req_va,
    input  logic [2*PCID_W-1:0] req_pcid,
    output logic [1:0]          req_ready,
    output logic [1:0]          rsp_valid,
    output logic [PA_W-1:0]     rsp_pa,
    output logic                rsp_fault,
    output logic                stlb_lookup,
    output logic [VA_W-1:0]     stlb_va,
    output logic [PCID_W-1:0]   stlb_pcid,
    output logic                stlb_insert,
    output logic [PA_W-1:0]     stlb_pa,
    output logic                stlb_shutdown,
    input  logic                stlb_hit,
    input  logic                stlb_miss,
    input  logic [PA_W-1:0]     stlb_ta,
    output logic                walk_req_valid,
    input  logic                walk_req_ready,
    input  logic                walk_rsp_valid,
    input  logic [PA_W-1:0]     walk_rsp_pa,
    input  logic                walk_rsp_fault,
    input  logic                flush_req,
    output logic                flush_ack,
    output logic                busy
);

    localparam int LAT_W = $clog2(STLB_LAT + 1) + 1;
    localparam int TO_W  = $clog2(WALK_TIMEOUT + 1) + 1;

    typedef enum logic [2:0] {
        S_IDLE, S_LOOKUP, S_WAIT_STLB, S_WALK_REQ,
        S_WALK_WAIT, S_INSERT, S_RESPOND, S_FLUSH
    } state_e;

    state_e              state_q, state_d;
    logic                rr_q, rr_d;
    logic                grant_q, grant_d;
    logic [VA_W-1:0]     va_q, va_d;
    logic [PCID_W-1:0]   pcid_q, pcid_d;
    logic [PA_W-1:0]     pa_q, pa_d;
    logic                fault_q, fault_d;
    logic [LAT_W-1:0]    lat_q, lat_d;
    logic [TO_W-1:0]     to_q, to_d;
    logic                gsel;

    // Round-robin pointer only matters when both requesters are valid
    assign gsel = (&req_valid) ? rr_q : req_valid[1];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            rr_q    <= 1'b0;
            grant_q <= 1'b0;
            va_q    <= '0;
            pcid_q  <= '0;
            pa_q    <= '0;
            fault_q <= 1'b0;
            lat_q   <= '0;
            to_q    <= '0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            grant_q <= grant_d;
            va_q    <= va_d;
            pcid_q  <= pcid_d;
            pa_q    <= pa_d;
            fault_q <= fault_d;
            lat_q   <= lat_d;
            to_q    <= to_d;
        end
    end

    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        grant_d = grant_q;
        va_d    = va_q;
        pcid_d  = pcid_q;
        pa_d    = pa_q;
        fault_d = fault_q;
        lat_d   = lat_q;
        to_d    = to_q;
        unique case (state_q)
            S_IDLE: begin
                if (flush_req) begin
                    state_d = S_FLUSH;
                end else if (|req_valid) begin
                    grant_d = gsel;
                    va_d    = gsel ? req_va[2*VA_W-1:VA_W] : req_va[VA_W-1:0];
                    pcid_d  = gsel ? req_pcid[2*PCID_W-1:PCID_W]
                                   : req_pcid[PCID_W-1:0];
                    state_d = S_LOOKUP;
                end
            end
            S_LOOKUP: begin
                lat_d   = LAT_W'(1);
                state_d = S_WAIT_STLB;
            end
            S_WAIT_STLB: begin
                if (lat_q >= LAT_W'(STLB_LAT)) begin
                    if (stlb_hit) begin
                        pa_d    = stlb_ta;
                        fault_d = 1'b0;
                        state_d = S_RESPOND;
                    end else if (stlb_miss) begin
                        state_d = S_WALK_REQ;
                    end
                end else begin
                    lat_d = lat_q + LAT_W'(1);
                end
            end
            S_WALK_REQ: begin
                if (walk_req_ready) begin
                    to_d    = '0;
                    state_d = S_WALK_WAIT;
                end
            end
            S_WALK_WAIT: begin
                if (walk_rsp_valid) begin
                    fault_d = walk_rsp_fault;
                    pa_d    = walk_rsp_fault ? '0 : walk_rsp_pa;
                    state_d = walk_rsp_fault ? S_RESPOND : S_INSERT;
                end else if (to_q == TO_W'(WALK_TIMEOUT)) begin
                    fault_d = 1'b1;
                    pa_d    = '0;
                    state_d = S_RESPOND;
                end else begin
                    to_d = to_q + TO_W'(1);
                end
            end
            S_INSERT:  state_d = S_RESPOND;
            S_RESPOND: begin
                rr_d    = ~grant_q;
                state_d = S_IDLE;
            end
            S_FLUSH:   state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    assign rsp_pa    = pa_q;
    assign stlb_pa   = pa_q;
    assign stlb_va   = va_q;
    assign stlb_pcid = pcid_q;

    always_comb begin
        req_ready      = 2'b00;
        rsp_valid      = 2'b00;
        rsp_fault      = 1'b0;
        stlb_lookup    = 1'b0;
        stlb_insert    = 1'b0;
        stlb_shutdown  = 1'b0;
        walk_req_valid = 1'b0;
        flush_ack      = 1'b0;
        busy           = (state_q != S_IDLE);
        unique case (state_q)
            S_IDLE: begin
                if (rst_n && !flush_req && (|req_valid))
                    req_ready = gsel ? 2'b10 : 2'b01;
            end
            S_LOOKUP:   stlb_lookup    = 1'b1;
            S_WALK_REQ: walk_req_valid = 1'b1;
            S_INSERT:   stlb_insert    = 1'b1;
            S_RESPOND: begin
                rsp_valid = grant_q ? 2'b10 : 2'b01;
                rsp_fault = fault_q;
            end
            S_FLUSH: begin
                stlb_shutdown = 1'b1;
                flush_ack     = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_tlb_miss_sequencer.sv
// Directed bench for tlb_miss_sequencer: cycle table for hit/walk paths,
// plus hand sequences for flush, fault, timeout, arbitration and reset.
module tb_tlb_miss_sequencer;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [1:0]   req_valid;
    logic [127:0] req_va;
    logic [23:0]  req_pcid;
    logic [1:0]   req_ready;
    logic [1:0]   rsp_valid;
    logic [63:0]  rsp_pa;
    logic         rsp_fault;
    logic         stlb_lookup;
    logic [63:0]  stlb_va;
    logic [11:0]  stlb_pcid;
    logic         stlb_insert;
    logic [63:0]  stlb_pa;
    logic         stlb_shutdown;
    logic         stlb_hit;
    logic         stlb_miss;
    logic [63:0]  stlb_ta;
    logic         walk_req_valid;
    logic         walk_req_ready;
    logic         walk_rsp_valid;
    logic [63:0]  walk_rsp_pa;
    logic         walk_rsp_fault;
    logic         flush_req;
    logic         flush_ack;
    logic         busy;

    int n_cmp = 0;
    int n_bad = 0;

    localparam logic [63:0] VA0 = 64'hFFFF_FFFF_FFFF_FFF1;
    localparam logic [63:0] VA1 = 64'h0000_1234_5678_9000;

    tlb_miss_sequencer dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_va(req_va), .req_pcid(req_pcid),
        .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_pa(rsp_pa),
        .rsp_fault(rsp_fault), .stlb_lookup(stlb_lookup),
        .stlb_va(stlb_va), .stlb_pcid(stlb_pcid),
        .stlb_insert(stlb_insert), .stlb_pa(stlb_pa),
        .stlb_shutdown(stlb_shutdown), .stlb_hit(stlb_hit),
        .stlb_miss(stlb_miss), .stlb_ta(stlb_ta),
        .walk_req_valid(walk_req_valid), .walk_req_ready(walk_req_ready),
        .walk_rsp_valid(walk_rsp_valid), .walk_rsp_pa(walk_rsp_pa),
        .walk_rsp_fault(walk_rsp_fault), .flush_req(flush_req),
        .flush_ack(flush_ack), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  rv;
        logic        hit;
        logic        miss;
        logic        wrdy;
        logic        wrsp;
        logic [63:0] wpa;
        logic [10:0] ctl;
        bit          cp;
        logic [63:0] pa;
        logic [11:0] pcid;
    } vec_t;

    vec_t v[17];

    function automatic logic [10:0] c(logic [1:0] rr, logic [1:0] rv,
        logic lk, logic ins, logic wrv, logic sd, logic fa, logic bz,
        logic rf);
        return {rr, rv, lk, ins, wrv, sd, fa, bz, rf};
    endfunction

    function automatic logic [10:0] ctl_now();
        return {req_ready, rsp_valid, stlb_lookup, stlb_insert,
                walk_req_valid, stlb_shutdown, flush_ack, busy, rsp_fault};
    endfunction

    function automatic vec_t mk(logic [1:0] rv, logic hit, logic miss,
        logic wrdy, logic wrsp, logic [63:0] wpa, logic [10:0] ctl,
        bit cp, logic [63:0] pa, logic [11:0] pcid);
        vec_t r;
        r.rv = rv; r.hit = hit; r.miss = miss; r.wrdy = wrdy;
        r.wrsp = wrsp; r.wpa = wpa; r.ctl = ctl; r.cp = cp;
        r.pa = pa; r.pcid = pcid;
        return r;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        req_valid = 2'b00; stlb_hit = 1'b0; stlb_miss = 1'b0;
        walk_req_ready = 1'b0; walk_rsp_valid = 1'b0;
        walk_rsp_pa = '0; walk_rsp_fault = 1'b0; flush_req = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic wait_rsp(input string nm, input logic [1:0] exp);
        for (int t = 0; t < 30 && rsp_valid == 2'b00; t++) tick();
        chk(nm, 64'(rsp_valid), 64'(exp));
    endtask

    // One request that misses in the STLB and goes to the walker
    task automatic walk_txn(input int idx, input bit give, input bit flt,
        input logic [63:0] pa, output int wcyc, output int ins,
        output logic [1:0] rv, output logic [63:0] rpa, output logic rf);
        bit hs;
        bit acc;
        hs = 0; acc = 0; wcyc = 0; ins = 0; rv = '0; rpa = '0; rf = 0;
        req_valid = (idx == 1) ? 2'b10 : 2'b01;
        stlb_hit = 1'b0; stlb_miss = 1'b1; walk_req_ready = 1'b1;
        for (int t = 0; t < 400 && rv == 2'b00; t++) begin
            if (acc) req_valid = 2'b00;
            walk_rsp_valid = give && hs && (wcyc == 2);
            walk_rsp_fault = flt;
            walk_rsp_pa = pa;
            #1;
            if ((req_ready & req_valid) != 2'b00) acc = 1;
            if (stlb_insert) ins++;
            if (rsp_valid != 2'b00) begin
                rv = rsp_valid; rpa = rsp_pa; rf = rsp_fault;
            end else if (hs) begin
                wcyc++;
            end
            if (walk_req_valid && walk_req_ready) hs = 1;
            tick();
        end
        idle_inputs();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int wc, ni;
        logic [1:0] rv;
        logic [63:0] rpa;
        logic rf;

        req_va   = {VA1, VA0};
        req_pcid = {12'd1, 12'd0};
        stlb_ta  = 64'h1000;

        v[0]  = mk(2'b01,0,0,0,0,0, c(2'b01,2'b00,0,0,0,0,0,0,0), 0,0,0);
        v[1]  = mk(2'b00,0,0,0,0,0, c(2'b00,2'b00,1,0,0,0,0,1,0), 0,0,0);
        v[2]  = mk(2'b00,1,0,0,0,0, c(2'b00,2'b00,0,0,0,0,0,1,0), 0,0,0);
        v[3]  = mk(2'b00,0,0,0,0,0, c(2'b00,2'b01,0,0,0,0,0,1,0),
                   1, 64'h1000, 12'd0);
        v[4]  = mk(2'b00,0,0,0,0,0, c(2'b00,2'b00,0,0,0,0,0,0,0),
                   1, 64'h1000, 12'd0);
        v[5]  = mk(2'b10,0,0,0,0,0, c(2'b10,2'b00,0,0,0,0,0,0,0), 0,0,0);
        v[6]  = mk(2'b00,0,0,0,0,0, c(2'b00,2'b00,1,0,0,0,0,1,0), 0,0,0);
        v[7]  = mk(2'b00,0,1,0,0,0, c(2'b00,2'b00,0,0,0,0,0,1,0), 0,0,0);
        v[8]  = mk(2'b00,0,0,1,0,0, c(2'b00,2'b00,0,0,1,0,0,1,0), 0,0,0);
        for (int i = 9; i < 13; i++)
            v[i] = mk(2'b00,0,0,0,0,0, c(2'b00,2'b00,0,0,0,0,0,1,0), 0,0,0);
        v[13] = mk(2'b00,0,0,0,1,64'h2000,
                   c(2'b00,2'b00,0,0,0,0,0,1,0), 0,0,0);
        v[14] = mk(2'b00,0,0,0,0,0, c(2'b00,2'b00,0,1,0,0,0,1,0),
                   1, 64'h2000, 12'd1);
        v[15] = mk(2'b00,0,0,0,0,0, c(2'b00,2'b10,0,0,0,0,0,1,0),
                   1, 64'h2000, 12'd1);
        v[16] = mk(2'b00,0,0,0,0,0, c(2'b00,2'b00,0,0,0,0,0,0,0),
                   1, 64'h2000, 12'd1);

        do_reset();
        chk("reset_outputs", 64'(|{req_ready, rsp_valid, rsp_pa, rsp_fault,
            stlb_lookup, stlb_va, stlb_pcid, stlb_insert, stlb_pa,
            stlb_shutdown, walk_req_valid, flush_ack, busy}), 64'd0);

        for (int i = 0; i < 17; i++) begin
            req_valid = v[i].rv; stlb_hit = v[i].hit; stlb_miss = v[i].miss;
            walk_req_ready = v[i].wrdy; walk_rsp_valid = v[i].wrsp;
            walk_rsp_pa = v[i].wpa; walk_rsp_fault = 1'b0;
            #1;
            chk($sformatf("row%0d_ctl", i), 64'(ctl_now()), 64'(v[i].ctl));
            if (v[i].cp) begin
                chk($sformatf("row%0d_rsp_pa", i), rsp_pa, v[i].pa);
                chk($sformatf("row%0d_stlb_pa", i), stlb_pa, v[i].pa);
                chk($sformatf("row%0d_pcid", i), 64'(stlb_pcid),
                    64'(v[i].pcid));
            end
            if (i == 1) chk("row1_stlb_va", stlb_va, VA0);
            if (i == 14) chk("row14_stlb_va", stlb_va, VA1);
            tick();
        end
        idle_inputs();

        // flush raised mid-walk waits, then beats the pending request
        req_valid = 2'b01; stlb_miss = 1'b1; walk_req_ready = 1'b1;
        #1 chk("fl_accept", 64'(req_ready), 64'(2'b01));
        tick();
        req_valid = 2'b10;
        #1 chk("fl_busy_rdy", 64'(req_ready), 64'(2'b00));
        tick();
        tick();
        chk("fl_walk_req", 64'(walk_req_valid), 64'd1);
        tick();
        flush_req = 1'b1;
        #1 chk("fl_wait_ack", 64'({flush_ack, busy}), 64'(2'b01));
        tick();
        walk_rsp_valid = 1'b1; walk_rsp_pa = 64'h3000;
        tick();
        walk_rsp_valid = 1'b0;
        chk("fl_insert", 64'(stlb_insert), 64'd1);
        tick();
        chk("fl_respond", 64'({rsp_valid, flush_ack}), 64'(3'b010));
        chk("fl_rsp_pa", rsp_pa, 64'h3000);
        tick();
        chk("fl_idle_block", 64'({req_ready, busy, stlb_shutdown}), 64'd0);
        tick();
        chk("fl_flush", 64'({stlb_shutdown, flush_ack, req_ready}),
            64'(4'b1100));
        flush_req = 1'b0;
        tick();
        chk("fl_after_ack", 64'({req_ready, flush_ack}), 64'(3'b100));
        stlb_hit = 1'b1; stlb_miss = 1'b0;
        tick();
        req_valid = 2'b00;
        wait_rsp("fl_pending_rsp", 2'b10);
        chk("fl_pending_pa", rsp_pa, 64'h1000);
        tick();
        idle_inputs();

        walk_txn(0, 1, 1, 64'h4000, wc, ni, rv, rpa, rf);
        chk("flt_rsp_valid", 64'(rv), 64'(2'b01));
        chk("flt_rsp_fault", 64'(rf), 64'd1);
        chk("flt_no_insert", 64'(ni), 64'd0);

        walk_txn(1, 0, 0, 64'h0, wc, ni, rv, rpa, rf);
        chk("to_rsp_valid", 64'(rv), 64'(2'b10));
        chk("to_rsp_fault", 64'(rf), 64'd1);
        chk("to_rsp_pa", rpa, 64'd0);
        chk("to_no_insert", 64'(ni), 64'd0);
        chk("to_latency_ok", 64'(wc >= 255 && wc <= 257), 64'd1);

        walk_txn(0, 1, 0, 64'h7000, wc, ni, rv, rpa, rf);
        chk("wk_rsp", 64'({rv, rf}), 64'(3'b010));
        chk("wk_pa", rpa, 64'h7000);
        chk("wk_one_insert", 64'(ni), 64'd1);

        // arbitration: both valid, grants alternate starting with ITLB
        do_reset();
        req_valid = 2'b11; stlb_hit = 1'b1;
        #1;
        for (int k = 0; k < 4; k++) begin
            for (int t = 0; t < 10 && req_ready == 2'b00; t++) tick();
            chk($sformatf("arb_grant%0d", k), 64'(req_ready),
                64'((k % 2) ? 2'b10 : 2'b01));
            tick();
        end
        req_valid = 2'b00;
        repeat (5) tick();
        idle_inputs();

        // reset in WALK_WAIT: no response, late walk result dropped
        req_valid = 2'b01; stlb_miss = 1'b1; walk_req_ready = 1'b1;
        tick();
        req_valid = 2'b00;
        tick();
        tick();
        tick();
        tick();
        chk("mr_in_walk", 64'({busy, walk_req_valid}), 64'(2'b10));
        rst_n = 1'b0;
        tick();
        chk("mr_zero", 64'(|{req_ready, rsp_valid, rsp_pa, rsp_fault,
            stlb_lookup, stlb_va, stlb_pcid, stlb_insert, stlb_pa,
            stlb_shutdown, walk_req_valid, flush_ack, busy}), 64'd0);
        rst_n = 1'b1;
        walk_rsp_valid = 1'b1; walk_rsp_pa = 64'h5000;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk($sformatf("mr_ignore%0d", k),
                64'({rsp_valid, stlb_insert, busy}), 64'd0);
            tick();
        end
        idle_inputs();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/tlb_miss_sequencer.md
Name: tlb_miss_sequencer

Overview:
- Arbitrates ITLB-side and DTLB-side translation misses onto the shared STLB and sequences each one.
- Per miss: STLB lookup; on STLB miss, a page-walk request; a fill (insert) into the STLB; a response to the requester.
- Also serialises STLB flush (shutdown) requests against in-flight misses.
- Sits inside MMU between first-level TLBs, STLB and the page walker.

Parameters:
VA_W, 64, virtual address width
PA_W, 64, physical address width
PCID_W, 12, process-context ID width
STLB_LAT, 1, cycles from stlb_lookup to stlb_hit/stlb_miss
WALK_TIMEOUT, 255, max cycles waiting in WALK_WAIT before forced fault

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
req_valid  in  2  miss request per requester (bit0 ITLB, bit1 DTLB), held until accepted
req_va  in  2*VA_W  per-requester VA (slice i for requester i)
req_pcid  in  2*PCID_W  per-requester PCID
req_ready  out  2  one-hot accept; handshake = req_valid[i] & req_ready[i]
rsp_valid  out  2  one-hot, one-cycle response pulse
rsp_pa  out  PA_W  translated address, valid with rsp_valid
rsp_fault  out  1  translation fault, valid with rsp_valid
stlb_lookup  out  1  one-cycle STLB probe strobe
stlb_va  out  VA_W  latched VA to STLB and walker
stlb_pcid  out  PCID_W  latched PCID to STLB and walker
stlb_insert  out  1  one-cycle STLB fill strobe
stlb_pa  out  PA_W  fill PA
stlb_shutdown  out  1  one-cycle STLB flush strobe
stlb_hit  in  1  STLB hit
stlb_miss  in  1  STLB miss
stlb_ta  in  PA_W  STLB translated address
walk_req_valid  out  1  walk request
walk_req_ready  in  1  walker accepts
walk_rsp_valid  in  1  walk result strobe
walk_rsp_pa  in  PA_W  walk PA
walk_rsp_fault  in  1  walk fault
flush_req  in  1  level flush request, held until flush_ack
flush_ack  out  1  one-cycle flush done
busy  out  1  state != IDLE

Behaviour:
- rst_n=0 at a clk edge: state IDLE; rr pointer=0 (ITLB wins first tie); all outputs 0; latched VA/PCID/PA and timeout counter cleared.
- Reset mid-transaction: abort without response; late walk_rsp/stlb results are ignored.
- States: IDLE, LOOKUP, WAIT_STLB, WALK_REQ, WALK_WAIT, INSERT, RESPOND, FLUSH.
- IDLE, flush_req=1: go FLUSH. Flush beats pending requests; req_ready stays 0 that cycle.
- IDLE, no flush: req_ready combinationally one-hot to the granted valid requester. Single valid requester wins. Both valid: requester rr wins.
- On handshake: latch req_va/req_pcid slice and grant index; go LOOKUP.
- LOOKUP: stlb_lookup=1 for one cycle; go WAIT_STLB.
- WAIT_STLB: count STLB_LAT cycles, then sample stlb_hit/stlb_miss.
  - hit (hit has priority if both high): latch stlb_ta, fault=0, go RESPOND.
  - miss: go WALK_REQ.
  - neither: stay, sampling each cycle.
- WALK_REQ: walk_req_valid=1 held until walk_req_ready; then go WALK_WAIT and clear the timeout counter.
- WALK_WAIT: wait for walk_rsp_valid.
  - fault=1: go RESPOND with fault=1, no insert.
  - else: latch walk_rsp_pa and go INSERT.
  - Counter reaches WALK_TIMEOUT: go RESPOND with fault=1, rsp_pa=0.
  - walk_rsp_valid outside WALK_WAIT is ignored.
- INSERT: stlb_insert=1 for one cycle, stlb_va/pcid/pa stable; go RESPOND.
- RESPOND: rsp_valid[grant]=1 one cycle with rsp_pa/rsp_fault; rr <= ~grant; go IDLE.
- FLUSH: stlb_shutdown=1 and flush_ack=1 in the same single cycle; go IDLE.
- flush_req arriving mid-transaction waits; it is taken on the next IDLE cycle, ahead of any request.
- stlb_va/pcid/pa and rsp_pa hold last values between transactions.
- Latency, STLB_LAT=1, handshake in cycle T:
  - stlb_lookup at T+1; result sampled at T+2; rsp_valid at T+3.
  - Walk path adds walk handshake + response wait + 1 insert cycle.
- One outstanding miss max; non-granted requester keeps req_valid high.

Test Plan:
- Reset, ITLB req VA=0xFFFF_FFFF_FFFF_FFF1 PCID=0, STLB hit ta=0x1000 next cycle -> req_ready[0] at T, stlb_lookup T+1, rsp_valid=2'b01 rsp_pa=0x1000 fault=0 at T+3, no stlb_insert.
- DTLB req PCID=1, STLB miss, walker ready immediately, rsp pa=0x2000 after 5 cycles -> walk_req_valid 1 cycle, stlb_insert 1 cycle with pcid=1 pa=0x2000, then rsp_valid=2'b10 pa=0x2000.
- Both requesters valid continuously, all STLB hits -> grants alternate 0,1,0,1; first grant ITLB after reset.
- flush_req raised during a WALK_WAIT -> walk completes and responds; next cycle IDLE→FLUSH; stlb_shutdown=flush_ack=1 one cycle; pending request accepted after.
- Walker returns fault=1 -> rsp_fault=1, no stlb_insert. Separately, walker silent -> fault response after WALK_TIMEOUT=255 cycles.
- rst_n=0 during WALK_WAIT -> all outputs 0 next cycle, no rsp_valid; subsequent walk_rsp_valid ignored, busy=0.
